prog_updown_counter: RTL and testbench
======================================

Name: prog_updown_counter

Overview:
- Parametrised successor to the team's 5-bit loadable up-counter.
- Adds up/down direction, a programmable terminal limit and three terminal modes (wrap, saturate, one-shot).
- Adds a clock-enable prescaler, a terminal-count pulse, and sticky overflow/done flags.
- Used as the generic event/timer counter in the training SoC; all outputs are registered.

Parameters:
- WIDTH, 5, count/data/limit width in bits (>=2).
- PRESCALE_W, 4, width of the prescale divisor input (>=1).
- RESET_VAL, '0, value of count after reset (WIDTH bits).

Ports:
- clk  input  1  clock, rising edge.
- rst_  input  1  asynchronous, active-low reset.
- load  input  1  synchronous load of data.
- data  input  WIDTH  load value.
- enable  input  1  count enable; gates the prescaler.
- up  input  1  direction: 1 = up, 0 = down.
- mode  input  2  mode_t: WRAP=0, SAT=1, ONESHOT=2; 3 is reserved and treated as WRAP.
- limit  input  WIDTH  upper terminal value (lower terminal is always 0).
- prescale  input  PRESCALE_W  tick every prescale+1 enabled cycles.
- clr_flags  input  1  clears ovf.
- count  output  WIDTH  current count.
- tc  output  1  one-cycle terminal-count pulse.
- ovf  output  1  sticky: a step past a terminal was attempted.
- done  output  1  one-shot finished.

Behaviour:
- Reset (rst_=0, asynchronous): count=RESET_VAL, tc=0, ovf=0, done=0, prescaler phase=0. Applies immediately, mid-operation included.
- Prescaler:
  - Internal phase counter psc advances only when enable=1.
  - tick = enable && (psc==prescale); on tick psc<=0, else psc<=psc+1.
  - enable=0 holds psc.
  - prescale=0 gives a tick every enabled cycle.
  - If prescale is lowered below psc, psc wraps via the == compare after rollover; no error.
- Priority per clk edge: load > tick > hold.
- Load:
  - count <= min(data, limit).
  - psc <= 0, done <= 0, tc <= 0.
  - Any tick in the same cycle is discarded.
  - ovf is not affected.
- Tick, direction up:
  - Terminal when count >= limit; otherwise count <= count+1.
  - WRAP: count <= 0.
  - SAT: count <= limit.
  - ONESHOT: count <= limit, done <= 1.
- Tick, direction down:
  - Terminal when count == 0; otherwise count <= count-1.
  - WRAP: count <= limit.
  - SAT: count <= 0.
  - ONESHOT: count <= 0, done <= 1.
- Terminal tick (all modes): tc=1 for the cycle following that edge, and ovf <= 1.
- done=1: ticks are ignored. Count holds, no tc, ovf unchanged. Only load or reset clears done.
- Non-tick cycles: tc=0.
- clr_flags clears ovf; if ovf is set in the same cycle, set wins.
- limit=0: every tick is terminal and count stays 0.
- mode, up and limit are sampled at each tick; changes mid-count take effect on the next tick.
- Latency: count reflects a tick or load one clk after the sampling edge.
- Arithmetic is unsigned, WIDTH bits; no carry escapes.

Decomposition:
- Package counter_pkg:
  - typedef enum logic [1:0] mode_t {WRAP, SAT, ONESHOT}.
  - Localparam defaults for WIDTH and PRESCALE_W.
- One sub-module, clk_en_prescaler (PRESCALE_W; ports clk, rst_, enable, restart, prescale, tick).
  - Instantiated once; restart is driven by load.
- Terminal/next-count logic stays in the top module: always_ff plus unique case on mode.

Test Plan:
1. WIDTH=5, count running at 13, drop rst_ between clk edges -> count=0, tc=ovf=done=0 with no clk edge; then rst_=1, up, WRAP, limit=31 counts 0,1,2.
2. WRAP, up, limit=9, prescale=0, enable=1 from 0 -> count 9 after 9 clks, 0 on clk 10; tc high only in cycle 11; ovf=1. clr_flags then -> ovf=0.
3. WRAP, down, limit=20, load 0 -> next tick count=20 with tc pulse. Load 25 -> count=20 (clamped).
4. SAT, up, limit=31, count=30 -> 31, then holds 31 on further ticks with a tc pulse each tick. clr_flags in the same cycle as a saturating tick -> ovf stays 1.
5. ONESHOT, up, prescale=2, limit=31, load 28 -> count steps every 3 enabled cycles, reaches 31 after 9 cycles. Next tick: done=1, one tc pulse. Further ticks: no change. Load 5 -> done=0, count=5.
6. Prescaler hold and load priority: prescale=3, drop enable for 4 cycles mid-phase -> no ticks, phase preserved. load=1 coincident with a tick -> count=data, next tick 4 enabled cycles later.

Source files
------------

// File: rtl/counter_pkg.sv
// counter_pkg: shared types and default widths for the programmable up/down counter.
// Revision 1.0
`default_nettype none

package counter_pkg;

  localparam int DEF_WIDTH      = 5;
  localparam int DEF_PRESCALE_W = 4;

  typedef enum logic [1:0] {
    WRAP    = 2'd0,
    SAT     = 2'd1,
    ONESHOT = 2'd2
  } mode_t;

endpackage

`default_nettype wire

// File: rtl/clk_en_prescaler.sv
// clk_en_prescaler: emits a tick every prescale+1 enabled cycles; restart zeroes the phase.
// Revision 1.0
`default_nettype none

module clk_en_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic                  enable,
  input  logic                  restart,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] r_psc;

  // Equality compare lets a phase beyond a lowered divisor roll over naturally.
  assign tick = enable && (r_psc == prescale);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_psc <= '0;
    end else if (restart) begin
      r_psc <= '0;
    end else if (enable) begin
      if (tick) begin
        r_psc <= '0;
      end else begin
        r_psc <= r_psc + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/prog_updown_counter.sv
// prog_updown_counter: prescaled up/down counter with programmable limit, wrap/sat/one-shot modes.
// Revision 1.0
`default_nettype none

module prog_updown_counter
  import counter_pkg::*;
#(
  parameter int               WIDTH      = DEF_WIDTH,
  parameter int               PRESCALE_W = DEF_PRESCALE_W,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic                  load,
  input  logic [WIDTH-1:0]      data,
  input  logic                  enable,
  input  logic                  up,
  input  logic [1:0]            mode,
  input  logic [WIDTH-1:0]      limit,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  clr_flags,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  ovf,
  output logic                  done
);

  logic             w_tick;
  logic             w_step;
  logic             w_term;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_load_val;

  clk_en_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .rst_     (rst_),
    .enable   (enable),
    .restart  (load),
    .prescale (prescale),
    .tick     (w_tick)
  );

  assign w_load_val = (data > limit) ? limit : data;
  assign w_step     = w_tick && !load && !done;

  // Next count for a tick; reserved mode encoding falls into the wrap branch.
  always_comb begin
    w_next = count;
    w_term = 1'b0;
    if (up) begin
      if (count >= limit) begin
        w_term = 1'b1;
        unique case (mode)
          SAT, ONESHOT: w_next = limit;
          default:      w_next = '0;
        endcase
      end else begin
        w_next = count + 1'b1;
      end
    end else begin
      if (count == '0) begin
        w_term = 1'b1;
        unique case (mode)
          SAT, ONESHOT: w_next = '0;
          default:      w_next = limit;
        endcase
      end else begin
        w_next = count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      count <= RESET_VAL;
      tc    <= 1'b0;
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (load) begin
        count <= w_load_val;
        done  <= 1'b0;
      end else if (w_step) begin
        count <= w_next;
        if (w_term) begin
          tc <= 1'b1;
          if (mode == ONESHOT) begin
            done <= 1'b1;
          end
        end
      end
      // Setting takes precedence over a simultaneous clear.
      if (w_step && w_term) begin
        ovf <= 1'b1;
      end else if (clr_flags) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_prog_updown_counter.sv
// tb_prog_updown_counter: directed self-checking bench for prog_updown_counter.
// Revision 1.0
`default_nettype none

module tb_prog_updown_counter;
  import counter_pkg::*;

  logic       clk = 1'b0;
  logic       rst_;
  logic       load;
  logic [4:0] data;
  logic       enable;
  logic       up;
  logic [1:0] mode;
  logic [4:0] limit;
  logic [3:0] prescale;
  logic       clr_flags;
  logic [4:0] count;
  logic       tc;
  logic       ovf;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  prog_updown_counter dut (
    .clk       (clk),
    .rst_      (rst_),
    .load      (load),
    .data      (data),
    .enable    (enable),
    .up        (up),
    .mode      (mode),
    .limit     (limit),
    .prescale  (prescale),
    .clr_flags (clr_flags),
    .count     (count),
    .tc        (tc),
    .ovf       (ovf),
    .done      (done)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [4:0] val);
    load = 1'b1;
    data = val;
    step(1);
    load = 1'b0;
  endtask

  initial begin
    rst_ = 1'b0; load = 1'b0; data = '0; enable = 1'b0; up = 1'b1;
    mode = 2'd0; limit = 5'd31; prescale = '0; clr_flags = 1'b0;
    step(2);
    check("rst_count", count, 0);
    check("rst_tc", tc, 0);
    check("rst_ovf", ovf, 0);
    check("rst_done", done, 0);

    // 1: async reset mid-count
    rst_ = 1'b1; enable = 1'b1;
    step(13);
    check("t1_count13", count, 13);
    #2 rst_ = 1'b0;
    #1;
    check("t1_async_count", count, 0);
    check("t1_async_tc", tc, 0);
    check("t1_async_ovf", ovf, 0);
    check("t1_async_done", done, 0);
    rst_ = 1'b1;
    step(1);
    check("t1_count1", count, 1);
    step(1);
    check("t1_count2", count, 2);

    // 2: wrap up, limit 9
    limit = 5'd9;
    do_load(5'd0);
    check("t2_load0", count, 0);
    step(9);
    check("t2_count9", count, 9);
    check("t2_tc_pre", tc, 0);
    check("t2_ovf_pre", ovf, 0);
    step(1);
    check("t2_wrap", count, 0);
    check("t2_tc", tc, 1);
    check("t2_ovf", ovf, 1);
    step(1);
    check("t2_tc_drop", tc, 0);
    check("t2_count1", count, 1);
    clr_flags = 1'b1;
    step(1);
    clr_flags = 1'b0;
    check("t2_ovf_clr", ovf, 0);

    // 3: wrap down, limit 20, clamp on load
    limit = 5'd20; up = 1'b0;
    do_load(5'd0);
    check("t3_load0", count, 0);
    step(1);
    check("t3_wrap", count, 20);
    check("t3_tc", tc, 1);
    check("t3_ovf", ovf, 1);
    step(1);
    check("t3_dec", count, 19);
    check("t3_tc_drop", tc, 0);
    do_load(5'd25);
    check("t3_clamp", count, 20);
    check("t3_load_tc", tc, 0);

    // 4: saturate up
    mode = 2'd1; up = 1'b1; limit = 5'd31;
    do_load(5'd30);
    check("t4_load30", count, 30);
    clr_flags = 1'b1;
    step(1);
    clr_flags = 1'b0;
    check("t4_count31", count, 31);
    check("t4_ovf_clr", ovf, 0);
    check("t4_tc0", tc, 0);
    step(1);
    check("t4_hold", count, 31);
    check("t4_tc", tc, 1);
    check("t4_ovf", ovf, 1);
    clr_flags = 1'b1;
    step(1);
    clr_flags = 1'b0;
    check("t4_hold2", count, 31);
    check("t4_tc2", tc, 1);
    check("t4_set_wins", ovf, 1);

    // 5: one-shot with prescale 2
    mode = 2'd2; prescale = 4'd2;
    do_load(5'd28);
    check("t5_load28", count, 28);
    check("t5_done_clr", done, 0);
    step(2);
    check("t5_no_tick", count, 28);
    step(1);
    check("t5_count29", count, 29);
    step(6);
    check("t5_count31", count, 31);
    check("t5_done_pre", done, 0);
    step(3);
    check("t5_done", done, 1);
    check("t5_tc", tc, 1);
    check("t5_hold", count, 31);
    for (int i = 0; i < 6; i++) begin
      step(1);
      check("t5_no_tc", tc, 0);
    end
    check("t5_hold2", count, 31);
    check("t5_done_hold", done, 1);
    do_load(5'd5);
    check("t5_reload", count, 5);
    check("t5_done_reload", done, 0);

    // 6: prescaler hold and load priority
    mode = 2'd0; prescale = 4'd3;
    do_load(5'd0);
    step(2);
    enable = 1'b0;
    step(4);
    check("t6_hold_en", count, 0);
    enable = 1'b1;
    step(1);
    check("t6_pre_tick", count, 0);
    step(1);
    check("t6_tick", count, 1);
    step(3);
    check("t6_phase3", count, 1);
    do_load(5'd10);
    check("t6_load_wins", count, 10);
    step(3);
    check("t6_wait", count, 10);
    step(1);
    check("t6_next_tick", count, 11);

    // limit 0: every tick terminal, count stays 0
    prescale = 4'd0; limit = 5'd0; up = 1'b1;
    do_load(5'd7);
    check("lim0_load", count, 0);
    step(1);
    check("lim0_count", count, 0);
    check("lim0_tc", tc, 1);
    up = 1'b0;
    step(1);
    check("lim0_down", count, 0);
    check("lim0_tc_down", tc, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
